// File: rtl/sdram_line_arbiter.sv
// sdram_line_arbiter: grants one channel at a time and moves a full line between
// its buffer and SDRAM as 2^SEG_W bursts of 2^BURST_W words.
module sdram_line_arbiter #(
    parameter int NCH     = 2,
    parameter int LINE_W  = 12,
    parameter int SEG_W   = 2,
    parameter int BURST_W = 8,
    parameter int ARB_RR  = 0,
    localparam int ADDR_W = LINE_W + SEG_W + BURST_W,
    localparam int BA_W   = SEG_W + BURST_W
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [NCH-1:0]          ch_req,
    input  logic [NCH-1:0]          ch_write,
    input  logic [NCH*LINE_W-1:0]   ch_line_addr,
    output logic [NCH-1:0]          ch_ack,
    output logic [ADDR_W-1:0]       sdram_rw_addr,
    output logic                    sdram_rd_req,
    output logic                    sdram_wr_req,
    output logic [9:0]              sdram_rd_burst,
    output logic [9:0]              sdram_wr_burst,
    input  logic                    sdram_rd_ack,
    input  logic                    sdram_wr_ack,
    input  logic [15:0]             sdram_dout,
    output logic [15:0]             sdram_din,
    output logic                    buf_wr_en,
    output logic [BA_W-1:0]         buf_wr_addr,
    output logic [15:0]             buf_wr_data,
    output logic [1:0]              buf_sel,
    output logic [BA_W-1:0]         buf_rd_addr,
    input  logic [15:0]             buf_rd_data,
    output logic                    busy
);
    typedef enum logic [2:0] {IDLE, ISSUE, XFER, GAP, DONE} state_t;

    localparam logic [9:0] BLEN = 10'(2 ** BURST_W);

    state_t              state_q;
    logic [NCH-1:0]      req_s_q, ack_q;
    logic [1:0]          g_q, rr_q;
    logic                wr_q;
    logic [LINE_W-1:0]   line_q;
    logic [SEG_W-1:0]    seg_q;
    logic [BURST_W-1:0]  cnt_q;
    logic                rd_req_q, wr_req_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                bwe_q;
    logic [BA_W-1:0]     bwa_q;
    logic [15:0]         bwd_q;

    logic [NCH-1:0]      elig, g_oh;
    logic [1:0]          gnt_d;
    logic                gnt_v, sel_wr, req_g, xack;
    logic [LINE_W-1:0]   sel_line;
    logic [SEG_W-1:0]    seg_d;

    always_comb begin
        elig     = req_s_q & ~ack_q;
        gnt_v    = |elig;
        gnt_d    = '0;
        sel_line = '0;
        sel_wr   = 1'b0;
        g_oh     = '0;
        if (ARB_RR != 0) begin
            // walk from farthest to nearest after the last grant so the nearest wins
            for (int k = NCH; k >= 1; k--)
                for (int j = 0; j < NCH; j++)
                    if (elig[j] && j == (int'(rr_q) + k) % NCH) gnt_d = 2'(j);
        end else begin
            for (int j = NCH - 1; j >= 0; j--)
                if (elig[j]) gnt_d = 2'(j);
        end
        for (int j = 0; j < NCH; j++) begin
            if (gnt_d == 2'(j)) begin
                sel_line = ch_line_addr[j*LINE_W +: LINE_W];
                sel_wr   = ch_write[j];
            end
            g_oh[j] = (g_q == 2'(j));
        end
        req_g = |(req_s_q & g_oh);
        xack  = wr_q ? sdram_wr_ack : sdram_rd_ack;
        seg_d = seg_q + 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            req_s_q  <= '0;
            ack_q    <= '0;
            g_q      <= '0;
            rr_q     <= '0;
            wr_q     <= 1'b0;
            line_q   <= '0;
            seg_q    <= '0;
            cnt_q    <= '0;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            addr_q   <= '0;
            bwe_q    <= 1'b0;
            bwa_q    <= '0;
            bwd_q    <= '0;
        end else begin
            req_s_q <= ch_req;
            bwe_q   <= 1'b0;
            case (state_q)
                IDLE: if (gnt_v) begin
                    g_q      <= gnt_d;
                    rr_q     <= gnt_d;
                    wr_q     <= sel_wr;
                    line_q   <= sel_line;
                    seg_q    <= '0;
                    addr_q   <= {sel_line, {SEG_W{1'b0}}, {BURST_W{1'b0}}};
                    rd_req_q <= !sel_wr;
                    wr_req_q <= sel_wr;
                    state_q  <= ISSUE;
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= XFER;
                end
                XFER: if (xack) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!wr_q) begin
                        bwe_q <= 1'b1;
                        bwa_q <= {seg_q, cnt_q};
                        bwd_q <= sdram_dout;
                    end
                    if (&cnt_q) begin
                        rd_req_q <= 1'b0;
                        wr_req_q <= 1'b0;
                        state_q  <= GAP;
                    end
                end
                GAP: if (&seg_q) begin
                    ack_q   <= ack_q | g_oh;
                    state_q <= DONE;
                end else begin
                    seg_q    <= seg_d;
                    addr_q   <= {line_q, seg_d, {BURST_W{1'b0}}};
                    rd_req_q <= !wr_q;
                    wr_req_q <= wr_q;
                    state_q  <= ISSUE;
                end
                DONE: if (!req_g) begin
                    ack_q   <= ack_q & ~g_oh;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // read-ahead by one word whenever the controller takes the current one
    assign buf_rd_addr    = (state_q == ISSUE) ? {seg_q, {BURST_W{1'b0}}}
                          : {seg_q, cnt_q + BURST_W'(state_q == XFER && sdram_wr_ack)};
    assign sdram_din      = (state_q == XFER && wr_q) ? buf_rd_data : 16'h0;
    assign sdram_rw_addr  = addr_q;
    assign sdram_rd_req   = rd_req_q;
    assign sdram_wr_req   = wr_req_q;
    assign sdram_rd_burst = BLEN;
    assign sdram_wr_burst = BLEN;
    assign buf_wr_en      = bwe_q;
    assign buf_wr_addr    = bwa_q;
    assign buf_wr_data    = bwd_q;
    assign buf_sel        = g_q;
    assign ch_ack         = ack_q;
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_sdram_line_arbiter.sv
// tb_sdram_line_arbiter: directed checks of line transfers, arbitration and reset.
module tb_sdram_line_arbiter;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    logic [1:0]  ch_req, ch_write, ch_ack, bsel;
    logic [23:0] ch_line_addr;
    logic [21:0] rw_addr;
    logic        rd_req, wr_req, rd_ack, wr_ack, bwe, busy;
    logic [9:0]  rd_burst, wr_burst, bwa, bra;
    logic [15:0] dout, din, bwd, brd;

    sdram_line_arbiter dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .ch_req(ch_req), .ch_write(ch_write),
        .ch_line_addr(ch_line_addr), .ch_ack(ch_ack), .sdram_rw_addr(rw_addr),
        .sdram_rd_req(rd_req), .sdram_wr_req(wr_req), .sdram_rd_burst(rd_burst),
        .sdram_wr_burst(wr_burst), .sdram_rd_ack(rd_ack), .sdram_wr_ack(wr_ack),
        .sdram_dout(dout), .sdram_din(din), .buf_wr_en(bwe), .buf_wr_addr(bwa),
        .buf_wr_data(bwd), .buf_sel(bsel), .buf_rd_addr(bra), .buf_rd_data(brd), .busy(busy)
    );

    // small round-robin instance
    logic [1:0]  r_req, r_write, r_ack, r_bsel, r_want;
    logic [7:0]  r_line;
    logic [6:0]  r_addr;
    logic        r_rd_req, r_wr_req, r_rd_ack, r_wr_ack, r_bwe, r_busy;
    logic [9:0]  r_rdb, r_wrb;
    logic [15:0] r_dout, r_din, r_bwd, r_brd;
    logic [2:0]  r_bwa, r_bra;

    sdram_line_arbiter #(.NCH(2), .LINE_W(4), .SEG_W(1), .BURST_W(2), .ARB_RR(1)) rr (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .ch_req(r_req), .ch_write(r_write),
        .ch_line_addr(r_line), .ch_ack(r_ack), .sdram_rw_addr(r_addr),
        .sdram_rd_req(r_rd_req), .sdram_wr_req(r_wr_req), .sdram_rd_burst(r_rdb),
        .sdram_wr_burst(r_wrb), .sdram_rd_ack(r_rd_ack), .sdram_wr_ack(r_wr_ack),
        .sdram_dout(r_dout), .sdram_din(r_din), .buf_wr_en(r_bwe), .buf_wr_addr(r_bwa),
        .buf_wr_data(r_bwd), .buf_sel(r_bsel), .buf_rd_addr(r_bra), .buf_rd_data(r_brd), .busy(r_busy)
    );

    // buffer whose word k holds k, one-cycle read latency
    always @(posedge sys_clk) brd <= {6'b0, bra};

    int checks = 0, errors = 0;
    int n_r, n_w, n_k, nb, stall_at, stall_n, r_n;
    int r_g[4];
    logic prev_rd, prev_wr, r_prev, r_prev_busy;
    logic [11:0] exp_line;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int n);
        return 16'hA5C3 ^ 16'(n);
    endfunction

    task automatic start_line(input logic [11:0] line);
        exp_line = line;
        n_r = 0; n_w = 0; n_k = 0; nb = 0; stall_n = 0;
    endtask

    task automatic tick();
        logic give;
        @(posedge sys_clk); #1;
        chk("buf_wr_en", bwe, rd_ack && !sys_rst);
        if (bwe) begin
            chk("buf_wr_addr", bwa, n_w);
            chk("buf_wr_data", bwd, pat(n_w));
            n_w++;
        end
        if ((rd_req && !prev_rd) || (wr_req && !prev_wr)) begin
            chk("rw_addr", rw_addr, {exp_line, nb[1:0], 8'h00});
            nb++;
        end
        give = rd_req && prev_rd;
        if (give && n_r == stall_at && stall_n < 3) begin
            give = 1'b0;
            stall_n++;
        end
        rd_ack = give;
        if (give) begin
            dout = pat(n_r);
            n_r++;
        end
        wr_ack = wr_req && prev_wr;
        if (wr_ack) begin
            chk("sdram_din", din, n_k);
            n_k++;
        end
        prev_rd = rd_req;
        prev_wr = wr_req;
        r_rd_ack = r_rd_req && r_prev;
        r_prev = r_rd_req;
        for (int c = 0; c < 2; c++)
            if (r_ack[c]) r_req[c] = 1'b0;
            else if (r_want[c]) r_req[c] = 1'b1;
        if (r_busy && !r_prev_busy && r_n < 4) begin
            r_g[r_n] = int'(r_bsel);
            r_n++;
        end
        r_prev_busy = r_busy;
    endtask

    task automatic wait_ack(input int ch, input int lim);
        for (int i = 0; i < lim && !ch_ack[ch]; i++) tick();
        chk("ack_rise", ch_ack[ch], 1);
    endtask

    initial begin
        ch_req = '0; ch_write = '0; ch_line_addr = '0; rd_ack = 0; wr_ack = 0; dout = '0;
        r_req = '0; r_write = '0; r_line = {4'h9, 4'h6}; r_rd_ack = 0; r_wr_ack = 0;
        r_dout = '0; r_brd = '0; r_want = '0; r_n = 0; r_prev = 0; r_prev_busy = 0;
        prev_rd = 0; prev_wr = 0; stall_at = -1;
        for (int k = 0; k < 4; k++) r_g[k] = 7;
        start_line(12'h000);
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_ack", ch_ack, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_rw_addr", rw_addr, 0);
        chk("rst_din", din, 0);
        chk("rd_burst", rd_burst, 256);
        chk("wr_burst", wr_burst, 256);
        chk("rr_rst_busy", r_busy, 0);
        sys_rst = 0;

        // round robin: ch0 alone first, then both keep requesting
        r_want[0] = 1'b1;
        repeat (4) tick();
        r_want[1] = 1'b1;
        for (int i = 0; i < 400 && r_n < 4; i++) tick();
        chk("rr_grants_seen", r_n, 4);
        for (int k = 0; k < 4; k++) chk("rr_grant", r_g[k], k % 2);
        r_want = '0;
        repeat (30) tick();

        // ch0 reads line 5 with a 3-cycle ack gap mid-burst
        start_line(12'h005);
        stall_at = 300;
        ch_write = 2'b00; ch_line_addr = {12'h000, 12'h005}; ch_req = 2'b01;
        wait_ack(0, 3000);
        chk("rd_sel", bsel, 0);
        chk("rd_words", n_w, 1024);
        chk("rd_bursts", nb, 4);
        chk("rd_stalls", stall_n, 3);
        ch_req = 2'b00;
        tick();
        chk("ack_held", ch_ack, 2'b01);
        tick();
        chk("ack_clear", ch_ack, 0);
        chk("idle_busy", busy, 0);
        stall_at = -1;

        // fixed priority: both request, ch0 first
        start_line(12'h0AB);
        ch_line_addr = {12'h123, 12'h0AB}; ch_req = 2'b11;
        wait_ack(0, 3000);
        chk("fp_first_ack", ch_ack, 2'b01);
        chk("fp_first_sel", bsel, 0);
        chk("fp_first_words", n_w, 1024);
        ch_req[0] = 1'b0;
        start_line(12'h123);
        wait_ack(1, 3000);
        chk("fp_second_sel", bsel, 1);
        chk("fp_second_words", n_w, 1024);
        chk("fp_second_bursts", nb, 4);
        ch_req = 2'b00;
        repeat (2) tick();
        chk("fp_idle", busy, 0);

        // reset at word 100 of segment 2
        start_line(12'h005);
        ch_line_addr = {12'h000, 12'h005}; ch_req = 2'b01;
        for (int i = 0; i < 3000 && n_r < 613; i++) tick();
        chk("reached_word", n_r, 613);
        sys_rst = 1; ch_req = 2'b00;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd_req", rd_req, 0);
        chk("mid_rst_wr_req", wr_req, 0);
        chk("mid_rst_addr", rw_addr, 0);
        chk("mid_rst_bwe", bwe, 0);
        chk("mid_rst_ack", ch_ack, 0);
        chk("mid_rst_din", din, 0);
        chk("mid_rst_sel", bsel, 0);
        sys_rst = 0;

        // ch1 writes line 3 and drops its request mid-transfer
        start_line(12'h003);
        ch_write = 2'b10; ch_line_addr = {12'h003, 12'h000}; ch_req = 2'b10;
        for (int i = 0; i < 3000 && n_k < 500; i++) tick();
        ch_req = 2'b00;
        wait_ack(1, 3000);
        chk("wr_words", n_k, 1024);
        chk("wr_bursts", nb, 4);
        chk("wr_sel", bsel, 1);
        tick();
        chk("wr_ack_pulse", ch_ack, 0);
        chk("wr_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_line_arbiter.md
SDRAM_LINE_ARBITER -- requirements
Module: sdram_line_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 2: number of requesting channels (1..4).
REQ-002 SHALL have parameter LINE_W, default 12: line address width.
REQ-003 SHALL have parameter SEG_W, default 2: segments per line = 2^SEG_W.
REQ-004 SHALL have parameter BURST_W, default 8: words per segment burst = 2^BURST_W.
REQ-005 SHALL have parameter ARB_RR, default 0: 0 = fixed priority (channel 0 highest), 1 = round-robin.
REQ-006 SHALL have derived width ADDR_W = LINE_W+SEG_W+BURST_W (default 22).
REQ-007 SHALL have port sys_clk  in  1  sole clock, rising edge.
REQ-008 SHALL have port sys_rst  in  1  reset, synchronous, active-high.
REQ-009 SHALL have port ch_req  in  NCH  per-channel level request (4-phase).
REQ-010 SHALL have port ch_write  in  NCH  per-channel direction, 1 = buffer-to-SDRAM.
REQ-011 SHALL have port ch_line_addr  in  NCH*LINE_W  per-channel line address, channel i at bits [i*LINE_W +: LINE_W].
REQ-012 SHALL have port ch_ack  out  NCH  per-channel completion acknowledge.
REQ-013 SHALL have port sdram_rw_addr  out  ADDR_W  controller burst start address.
REQ-014 SHALL have ports sdram_rd_req, sdram_wr_req  out  1 each, and sdram_rd_burst, sdram_wr_burst  out  10  burst length.
REQ-015 SHALL have ports sdram_rd_ack, sdram_wr_ack  in  1 each  controller per-word strobes.
REQ-016 SHALL have ports sdram_dout  in  16, sdram_din  out  16.
REQ-017 SHALL have ports buf_wr_en  out  1, buf_wr_addr  out  SEG_W+BURST_W, buf_wr_data  out  16, buf_sel  out  2 (granted channel index).
REQ-018 SHALL have ports buf_rd_addr  out  SEG_W+BURST_W, buf_rd_data  in  16 (one-cycle registered read latency).
REQ-019 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-020 SHALL register ch_req through one flop (req_s) before any use; ch_write and ch_line_addr sampled at grant and held.
REQ-021 SHALL implement states IDLE, ISSUE, XFER, GAP, DONE.
REQ-022 IDLE: SHALL grant channel g with req_s[g]=1 and ch_ack[g]=0; fixed priority picks lowest index; RR picks first eligible index after last grant, modulo NCH; seg<=0; next ISSUE.
REQ-023 ISSUE (1 cycle): SHALL drive sdram_rw_addr={line,seg,BURST_W'b0}, burst length 2^BURST_W, assert rd_req or wr_req per direction, cnt<=0; next XFER.
REQ-024 XFER read: each cycle sdram_rd_ack=1 SHALL produce next-cycle buf_wr_en=1, buf_wr_addr={seg,cnt}, buf_wr_data=sdram_dout; cnt increments.
REQ-025 XFER write: buf_rd_addr SHALL equal {seg,cnt+sdram_wr_ack}, so sdram_din=buf_rd_data holds word cnt when wr_ack is high; in ISSUE buf_rd_addr={seg,0}.
REQ-026 On ack with cnt=2^BURST_W-1, SHALL deassert controller req next edge and enter GAP.
REQ-027 GAP (1 cycle page delay): if seg=2^SEG_W-1 go DONE with ch_ack[g]<=1, else seg+1 and ISSUE.
REQ-028 DONE: SHALL hold ch_ack[g] until req_s[g]=0, then clear ch_ack[g] and go IDLE; no new grant in the same cycle.
REQ-029 Channel dropping ch_req mid-transfer SHALL NOT abort; transfer completes, ack pulses one cycle then clears.
REQ-030 Controller req SHALL stay high from ISSUE through the last acked word; absent ack stalls cnt indefinitely.
REQ-031 Address arithmetic SHALL be width-exact concatenation, no carry between fields; cnt wraps only via REQ-026.
REQ-032 Simultaneous requests SHALL be served one full line at a time; RR pointer updates only at grant.

Reset
REQ-033 sys_rst=1 at an edge SHALL force state IDLE, ch_ack=0, req_s=0, sdram_rd_req=sdram_wr_req=0, buf_wr_en=0, busy=0, sdram_rw_addr=0, sdram_din=0, counters and RR pointer 0, regardless of transfer in progress; first grant possible 2 cycles after release.

Verification
REQ-034 Default params, ch0 read line 5, controller acks continuously -> 4 bursts, rw_addr 0x1400,0x1500,0x1600,0x1700; 1024 buf_wr_en pulses, addresses 0..1023; ch_ack[0] rises after last GAP.
REQ-035 ch1 write line 3, buffer word k = k -> sdram_din equals cnt on every wr_ack cycle; rw_addr starts 0x0C00.
REQ-036 ARB_RR=0, ch0 and ch1 request together -> ch0 served first; ARB_RR=1 with both held -> grants alternate 0,1,0,1.
REQ-037 Ack gaps: controller withholds rd_ack for 3 cycles mid-burst -> no buf_wr_en during gap, no lost or duplicated word.
REQ-038 sys_rst asserted at word 100 of segment 2 -> next cycle all outputs at reset values; new request completes normally.
